// File: rtl/fifo_stream_reader_if.sv
// Valid/ready word stream leaving the FIFO read-side drain engine.
interface fifo_stream_reader_if #(
    parameter int DSIZE = 8
);
    logic             m_valid;
    logic [DSIZE-1:0] m_data;
    logic             m_ready;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a registered-output dual-clock FIFO into a 2-entry prefetch buffer
// and presents it as a valid/ready stream with a delivered-word counter.
module fifo_stream_reader #(
    parameter int DSIZE = 8,
    parameter int CNTW  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  drain_en,
    input  logic                  fifo_rempty,
    input  logic [DSIZE-1:0]      fifo_rdata,
    output logic                  fifo_rinc,
    fifo_stream_reader_if.master  m,
    output logic [1:0]            occ,
    output logic [CNTW-1:0]       xfer_cnt
);
    logic             inflight;
    logic             valid_r;
    logic             pop;
    logic [DSIZE-1:0] head;
    logic [DSIZE-1:0] tail;
    logic [2:0]       occ_sum;

    assign pop     = valid_r & m.m_ready;
    // Occupancy after this edge; the in-flight read already holds a credit.
    assign occ_sum = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    assign fifo_rinc = rrst_n & drain_en & ~fifo_rempty & (occ_sum < 3'd2);
    assign m.m_valid = valid_r;
    assign m.m_data  = head;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ      <= '0;
            inflight <= 1'b0;
            valid_r  <= 1'b0;
            head     <= '0;
            tail     <= '0;
            xfer_cnt <= '0;
        end else begin
            inflight <= fifo_rinc;
            occ      <= occ_sum[1:0];
            valid_r  <= (occ_sum != 3'd0);
            if (pop)
                xfer_cnt <= xfer_cnt + 1'b1;
            if (inflight) begin
                if (occ == 2'd0 || (occ == 2'd1 && pop)) begin
                    head <= fifo_rdata;
                end else if (occ == 2'd1) begin
                    tail <= fifo_rdata;
                end else if (pop) begin
                    // Full and popping: old tail goes out next, new word queues behind.
                    head <= tail;
                    tail <= fifo_rdata;
                end
            end else if (pop && occ == 2'd2) begin
                head <= tail;
            end
        end
    end

    occ_bound: assert property (@(posedge rclk) disable iff (!rrst_n) occ_sum <= 3'd2)
        else $error("prefetch buffer overflow");
endmodule
